// File: rtl/cursor_pkg.sv
// Shared definitions for the terminal cursor controller: screen geometry
// defaults, the 3-bit move opcodes and the sequencing FSM state encoding.
package cursor_pkg;

  // Default screen geometry (column/row counts and the widths that hold them)
  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 24;
  localparam int DEF_XW   = 7;
  localparam int DEF_YW   = 5;

  // Cursor move opcodes, one 3-bit field per requester
  localparam logic [2:0] OP_CR    = 3'd0;
  localparam logic [2:0] OP_SET   = 3'd1;
  localparam logic [2:0] OP_UP    = 3'd2;
  localparam logic [2:0] OP_DOWN  = 3'd3;
  localparam logic [2:0] OP_LEFT  = 3'd4;
  localparam logic [2:0] OP_RIGHT = 3'd5;
  localparam logic [2:0] OP_HOME  = 3'd6;
  localparam logic [2:0] OP_LF    = 3'd7;

  // Move sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_SCROLL = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

endpackage

// File: rtl/cursor_rr_arbiter.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a
// tie; after each accepted grant it moves to the other requester.
module cursor_rr_arbiter (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o,
  output logic       ptr_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant the pointer requester if it asks, otherwise the other one
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    grant_o = 2'b00;
    ptr_d   = ptr_q;
    if (req_i[ptr_q]) begin
      grant_o[ptr_q] = 1'b1;
    end else if (req_i[~ptr_q]) begin
      grant_o[~ptr_q] = 1'b1;
    end
    if (advance_i && (|req_i)) begin
      ptr_d = grant_o[0];
    end
  end

  // Pointer register; requester 0 has priority out of reset
  always_ff @(posedge clk or posedge clr) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (clr) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/cursor_controller.sv
// Terminal cursor controller: owns the cursor column/row and sequences every
// move requested by the escape parser (0) or local echo (1), arbitrated
// round-robin. Each executed move pulses blink_rst; a line feed on the last
// row asks the screen memory to scroll before completing.
// Build option: define CURSOR_AUTOWRAP_EN to make RIGHT at the last column
// wrap to column 0 and behave as a line feed.
module cursor_controller
  import cursor_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int XW   = DEF_XW,
  parameter int YW   = DEF_YW
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [1:0]      req,
  input  logic [5:0]      op,
  input  logic [2*XW-1:0] arg_x,
  input  logic [2*YW-1:0] arg_y,
  output logic [1:0]      ack,
  output logic            busy,
  output logic [XW-1:0]   cursor_x,
  output logic [YW-1:0]   cursor_y,
  output logic            blink_rst,
  output logic            scroll_req,
  input  logic            scroll_ack
);

  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic [2:0]    op_q, op_d;
  logic [XW-1:0] ax_q, ax_d;
  logic [YW-1:0] ay_q, ay_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          advance;
  logic [1:0]    rr_grant;
  logic          rr_ptr;

  cursor_rr_arbiter u_arb (
    .clk       (clk),
    .clr       (clr),
    .req_i     (req),
    .advance_i (advance),
    .grant_o   (rr_grant),
    .ptr_o     (rr_ptr)
  );

  // Next-state logic: grant and latch in IDLE, compute the move in EXEC
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    x_d     = x_q;
    y_d     = y_q;
    advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          advance = 1'b1;
          gnt_d   = rr_grant[rr_ptr] ? rr_ptr : ~rr_ptr;
          op_d    = gnt_d ? op[5:3] : op[2:0];
          ax_d    = gnt_d ? arg_x[2*XW-1:XW] : arg_x[XW-1:0];
          ay_d    = gnt_d ? arg_y[2*YW-1:YW] : arg_y[YW-1:0];
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_ACK;
        case (op_q)
          OP_CR: x_d = '0;
          OP_SET: begin
            x_d = (ax_q > X_MAX) ? X_MAX : ax_q;
            y_d = (ay_q > Y_MAX) ? Y_MAX : ay_q;
          end
          OP_UP:   if (y_q != '0) y_d = y_q - 1'b1;
          OP_DOWN: if (y_q < Y_MAX) y_d = y_q + 1'b1;
          OP_LEFT: if (x_q != '0) x_d = x_q - 1'b1;
          OP_RIGHT: begin
            if (x_q < X_MAX) begin
              x_d = x_q + 1'b1;
            end else begin
`ifdef CURSOR_AUTOWRAP_EN
              // Wrap: column 0 on the next line, or scroll first on the last row
              if (y_q >= Y_MAX) begin
                state_d = ST_SCROLL;
              end else begin
                x_d = '0;
                y_d = y_q + 1'b1;
              end
`endif
            end
          end
          OP_HOME: begin
            x_d = '0;
            y_d = '0;
          end
          OP_LF: begin
            if (y_q >= Y_MAX) state_d = ST_SCROLL;
            else              y_d = y_q + 1'b1;
          end
          default: ;
        endcase
      end

      ST_SCROLL: begin
        // Position holds while scrolling; a wrapping RIGHT lands on column 0 afterwards
        if (scroll_ack) begin
          state_d = ST_ACK;
          if (op_q == OP_RIGHT) x_d = '0;
        end
      end

      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched request and position registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      op_q    <= OP_CR;
      ax_q    <= '0;
      ay_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Outputs decode straight from registered state, so they are glitch-free pulses
  assign busy       = (state_q != ST_IDLE);
  assign ack        = (state_q == ST_ACK) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign blink_rst  = (state_q == ST_ACK);
  assign scroll_req = (state_q == ST_SCROLL);
  assign cursor_x   = x_q;
  assign cursor_y   = y_q;

endmodule

// File: tb/tb_cursor_controller.sv
// Bench for cursor_controller: directed scenarios then randomized traffic from
// both requesters, checked against a behavioural model of the cursor rules.
module tb_cursor_controller;
  import cursor_pkg::*;

  localparam int COLS = 80;
  localparam int ROWS = 24;
  localparam int XW   = 7;
  localparam int YW   = 5;

  logic            clk = 1'b0;
  logic            clr = 1'b1;
  logic [1:0]      req = '0;
  logic [5:0]      op = '0;
  logic [2*XW-1:0] arg_x = '0;
  logic [2*YW-1:0] arg_y = '0;
  logic            scroll_ack = 1'b0;
  logic [1:0]      ack;
  logic            busy;
  logic [XW-1:0]   cursor_x;
  logic [YW-1:0]   cursor_y;
  logic            blink_rst;
  logic            scroll_req;

  cursor_controller dut (
    .clk        (clk),
    .clr        (clr),
    .req        (req),
    .op         (op),
    .arg_x      (arg_x),
    .arg_y      (arg_y),
    .ack        (ack),
    .busy       (busy),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .blink_rst  (blink_rst),
    .scroll_req (scroll_req),
    .scroll_ack (scroll_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int ax;
    int ay;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  int   mx, my, mptr;
  int   sdelay;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input int o, input int ax, input int ay);
    txn_t t;
    t.op = o;
    t.ax = ax;
    t.ay = ay;
    if (r == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  // Cursor rules in plain integer arithmetic; scr reports a scroll is needed
  function automatic void model(input txn_t t, inout int x, inout int y, output bit scr);
    scr = 1'b0;
    case (t.op)
      0: x = 0;
      1: begin
        x = (t.ax > COLS - 1) ? COLS - 1 : t.ax;
        y = (t.ay > ROWS - 1) ? ROWS - 1 : t.ay;
      end
      2: if (y > 0) y = y - 1;
      3: if (y < ROWS - 1) y = y + 1;
      4: if (x > 0) x = x - 1;
      5: begin
        if (x < COLS - 1) x = x + 1;
`ifdef CURSOR_AUTOWRAP_EN
        else begin
          x = 0;
          if (y == ROWS - 1) scr = 1'b1;
          else               y = y + 1;
        end
`endif
      end
      6: begin
        x = 0;
        y = 0;
      end
      default: begin
        if (y == ROWS - 1) scr = 1'b1;
        else               y = y + 1;
      end
    endcase
  endfunction

  // Present queued requests, track grants with the model, drain both queues.
  // Entered and left 1 time unit after a rising edge with the DUT idle.
  task automatic serve();
    while (q0.size() > 0 || q1.size() > 0) begin
      txn_t t;
      int   g, x0, y0, cyc, lat, blinks, sc;
      bit   scr, got;
      req = {q1.size() > 0, q0.size() > 0};
      if (q0.size() > 0) begin
        op[2:0]    = 3'(q0[0].op);
        arg_x[6:0] = 7'(q0[0].ax);
        arg_y[4:0] = 5'(q0[0].ay);
      end
      if (q1.size() > 0) begin
        op[5:3]     = 3'(q1[0].op);
        arg_x[13:7] = 7'(q1[0].ax);
        arg_y[9:5]  = 5'(q1[0].ay);
      end
      if (mptr == 0) g = (q0.size() > 0) ? 0 : 1;
      else           g = (q1.size() > 0) ? 1 : 0;
      mptr = 1 - g;
      t  = (g == 0) ? q0[0] : q1[0];
      x0 = mx;
      y0 = my;
      model(t, mx, my, scr);

      cyc = 0; lat = 0; blinks = 0; sc = 0; got = 1'b0;
      while (!got && cyc < 60) begin
        @(negedge clk);
        scroll_ack = 1'b0;
        if (cyc == 0) check("busy_idle", busy, 0);
        if (cyc == 1) check("busy_exec", busy, 1);
        if (blink_rst) blinks++;
        if (ack != 2'b00) begin
          got = 1'b1;
          lat = cyc;
        end else if (scroll_req) begin
          sc++;
          if (sc == 1) begin
            check("scroll_needed", 1, scr);
            check("scroll_hold_x", cursor_x, x0);
            check("scroll_hold_y", cursor_y, y0);
          end
          if (sc == sdelay) scroll_ack = 1'b1;
        end
        cyc++;
      end

      check("ack_seen", got, 1);
      if (!got) begin
        scroll_ack = 1'b0;
        req = '0;
        clr = 1'b1;
        q0.delete();
        q1.delete();
        mx = 0; my = 0; mptr = 0;
        @(negedge clk);
        clr = 1'b0;
      end else begin
        check("ack_onehot", ack, 1 << g);
        check("latency", lat, scr ? 2 + sdelay : 2);
        check("blink_count", blinks, 1);
        check("pos_x", cursor_x, mx);
        check("pos_y", cursor_y, my);
        if (g == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
      @(posedge clk);
      #1;
    end
    req = '0;
  endtask

  initial begin
    bit saw_ack;
    int waited;
    mx = 0; my = 0; mptr = 0; sdelay = 1;

    // Reset values while clr is held
    #12;
    check("rst_x", cursor_x, 0);
    check("rst_y", cursor_y, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_blink", blink_rst, 0);
    check("rst_scroll", scroll_req, 0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;

    // Absolute positioning, then clamping of out-of-range arguments
    push(0, OP_SET, 10, 5);
    push(0, OP_SET, 100, 30);
    serve();

    // Both requesters with three DOWNs each from row 0: grants alternate
    push(0, OP_HOME, 0, 0);
    serve();
    for (int i = 0; i < 3; i++) begin
      push(0, OP_DOWN, 0, 0);
      push(1, OP_DOWN, 0, 0);
    end
    serve();
    check("alt_down_y", cursor_y, 6);

    // Line feed on the last row waits five cycles for the scroll
    push(1, OP_SET, 33, 23);
    push(1, OP_LF, 0, 0);
    sdelay = 5;
    serve();

    // RIGHT at the last column, mid-screen and on the last row
    sdelay = 2;
    push(0, OP_SET, 79, 5);
    push(0, OP_RIGHT, 0, 0);
    push(0, OP_SET, 79, 23);
    push(0, OP_RIGHT, 0, 0);
    serve();

    // Saturation at the origin still blinks and acks
    push(1, OP_HOME, 0, 0);
    push(1, OP_LEFT, 0, 0);
    push(1, OP_UP, 0, 0);
    serve();

    // Reset while waiting for the scroll aborts with no ack
    push(0, OP_SET, 5, 23);
    serve();
    req = 2'b01;
    op[2:0] = OP_LF;
    waited = 0;
    while (!scroll_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("abort_scroll_seen", scroll_req, 1);
    @(negedge clk);
    #2;
    clr = 1'b1;
    #1;
    check("abort_x", cursor_x, 0);
    check("abort_y", cursor_y, 0);
    check("abort_scroll", scroll_req, 0);
    check("abort_busy", busy, 0);
    req = '0;
    #1;
    clr = 1'b0;
    mx = 0; my = 0; mptr = 0;
    saw_ack = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack != 2'b00) saw_ack = 1'b1;
    end
    check("abort_no_ack", saw_ack, 0);
    @(posedge clk);
    #1;

    // Randomized traffic from one or both requesters
    for (int r = 0; r < 40; r++) begin
      int sel;
      sel = $urandom_range(1, 3);
      for (int k = 0; k < 2; k++) begin
        if (sel[k]) begin
          int n;
          n = $urandom_range(1, 3);
          for (int j = 0; j < n; j++) begin
            int o;
            o = $urandom_range(0, 7);
            if (o == 1 && $urandom_range(0, 3) == 0)
              push(k, o, 79, 23);
            else
              push(k, o, $urandom_range(0, 127), $urandom_range(0, 31));
          end
        end
      end
      sdelay = $urandom_range(1, 4);
      serve();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
